// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/gnt/rvalid handshake,
// small instruction FIFO toward decode, and redirect flush with stale-response drop.
module if_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [4:0]      opcode
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] req_addr_reg, req_addr_next;
  logic            drop_reg, drop_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  logic            push;
  logic            pop;
  logic            fifo_valid;
  logic [CW:0]     count_after;
  logic [XLEN-1:0] redirect_aligned;

  logic [XLEN-1:0] ent_data [FIFO_DEPTH];
  logic [XLEN-1:0] ent_pc   [FIFO_DEPTH];

  assign fifo_valid       = (count_reg != '0);
  // A redirect in the same cycle as a handshake wins: the popped word is flushed anyway.
  assign pop              = fifo_valid && inst_ready && !redirect_valid;
  assign redirect_aligned = redirect_pc & ~(XLEN'(3));
  assign count_after      = {1'b0, count_reg} + (CW + 1)'(push) - (CW + 1)'(pop);

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    req_addr_next = req_addr_reg;
    drop_next     = drop_reg;
    push          = 1'b0;
    imem_req      = 1'b0;
    imem_addr     = pc_reg;

    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (({1'b0, count_reg} < DEPTH_C) && !redirect_valid) begin
            imem_req      = 1'b1;
            imem_addr     = pc_reg;
            req_addr_next = pc_reg;
            if (imem_gnt) begin
              pc_next    = pc_reg + XLEN'(4);
              state_next = WAIT;
            end else begin
              state_next = REQ;
            end
          end
        end

        REQ: begin
          // Address stays on the bus even if a redirect moved pc; that grant is then stale.
          imem_req  = 1'b1;
          imem_addr = req_addr_reg;
          if (redirect_valid) drop_next = 1'b1;
          if (imem_gnt) begin
            if (!drop_reg && !redirect_valid) pc_next = pc_reg + XLEN'(4);
            state_next = WAIT;
          end
        end

        WAIT: begin
          if (imem_rvalid) begin
            if (drop_reg) begin
              drop_next = 1'b0;
            end else if (!redirect_valid) begin
              push = 1'b1;
            end
            state_next = IDLE;
            if ((count_after < DEPTH_C) && !redirect_valid) begin
              imem_req      = 1'b1;
              imem_addr     = pc_reg;
              req_addr_next = pc_reg;
              if (imem_gnt) begin
                pc_next    = pc_reg + XLEN'(4);
                state_next = WAIT;
              end else begin
                state_next = REQ;
              end
            end
          end else if (redirect_valid) begin
            drop_next = 1'b1;
          end
        end

        default: state_next = IDLE;
      endcase

      if (redirect_valid) pc_next = redirect_aligned;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (redirect_valid) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      req_addr_reg <= RESET_PC;
      drop_reg     <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
      drop_reg     <= drop_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [XLEN-1:0] data_reg;
    logic [XLEN-1:0] epc_reg;

    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PW'(gi))) begin
        data_reg <= imem_rdata;
        epc_reg  <= req_addr_reg;
      end
    end

    assign ent_data[gi] = data_reg;
    assign ent_pc[gi]   = epc_reg;
  end

  assign inst_valid = fifo_valid;
  assign inst       = fifo_valid ? ent_data[rd_ptr_reg] : '0;
  assign inst_pc    = fifo_valid ? ent_pc[rd_ptr_reg] : '0;
  assign opcode     = inst[6:2];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table for reset and streaming,
// then hand-written cycle sequences for backpressure, redirects, PC wrap and mid-run reset.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [4:0]  opcode;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [4:0]  e_opc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check outputs at the falling edge.
  task automatic run(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    rst            = v.rst;
    imem_gnt       = v.gnt;
    imem_rvalid    = v.rvalid;
    imem_rdata     = v.rdata;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    inst_ready     = v.ready;
    @(negedge clk);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, v.e_req});
    if (v.e_req) chk({tag, ".addr"}, imem_addr, v.e_addr);
    chk({tag, ".iv"}, {31'b0, inst_valid}, {31'b0, v.e_iv});
    chk({tag, ".pc"}, inst_pc, v.e_pc);
    chk({tag, ".inst"}, inst, v.e_inst);
    chk({tag, ".opc"}, {27'b0, opcode}, {27'b0, v.e_opc});
    $display("cyc %-8s req=%0b addr=%08h iv=%0b pc=%08h inst=%08h opc=%0d",
             tag, imem_req, imem_addr, inst_valid, inst_pc, inst, opcode);
  endtask

  vec_t tbl [7];

  initial begin
    //           rst  gnt  rv   rdata         rd   rpc    rdy  req  addr   iv   pc     inst          opc
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,        5'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,        5'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h00000033, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0,        5'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h00002083, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 32'h00000033, 5'd12};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h00102023, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h4, 32'h00002083, 5'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'h00102023, 5'd8};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,        5'd0};

    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: FIFO fills to two, requests stop, drain restarts fetch at 0x8.
    run('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,        5'd0}, "bp_a");
    run('{1'b0, 1'b1, 1'b1, 32'h00000013, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0,        5'd0}, "bp_b");
    run('{1'b0, 1'b1, 1'b1, 32'h00100093, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h00000013, 5'd4}, "bp_c");
    run('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h00000013, 5'd4}, "bp_d");
    run('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h00000013, 5'd4}, "bp_e");
    run('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4, 32'h00100093, 5'd4}, "bp_f");
    run('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0,        5'd0}, "bp_g");

    // Redirect while waiting on 0x8: its data is dropped, fetch resumes at 0x100.
    run('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h103, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        5'd0}, "rd_h");
    run('{1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,        5'd0}, "rd_i");
    run('{1'b0, 1'b0, 1'b1, 32'h00000063, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0,        5'd0}, "rd_j");
    run('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b1, 32'h100, 32'h00000063, 5'd24}, "rd_k");

    // Redirect coinciding with a decode handshake, with a request still ungranted.
    run('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h200, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 32'h00000063, 5'd24}, "rh_l");
    run('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'h0,        5'd0}, "rh_m");
    run('{1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0,        5'd0}, "rh_n");
    run('{1'b0, 1'b0, 1'b1, 32'h00000073, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0,        5'd0}, "rh_o");
    run('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b1, 32'h200, 32'h00000073, 5'd28}, "rh_p");

    // Redirect to the top word: fetch must wrap to 0x0.
    run('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h204,      1'b0, 32'h0,        32'h0,        5'd0}, "wr_q");
    run('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h204,      1'b0, 32'h0,        32'h0,        5'd0}, "wr_r");
    run('{1'b0, 1'b1, 1'b1, 32'h00000099, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        32'h0,        5'd0}, "wr_s");
    run('{1'b0, 1'b1, 1'b1, 32'h00000037, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        5'd0}, "wr_t");
    run('{1'b0, 1'b0, 1'b1, 32'h00000017, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'hFFFFFFFC, 32'h00000037, 5'd13}, "wr_u");
    run('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b1, 32'h0,        32'h00000017, 5'd5}, "wr_v");

    // Reset while waiting: the late response must not reach the FIFO.
    run('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,        5'd0}, "rs_w");
    run('{1'b0, 1'b0, 1'b1, 32'h00000BAD, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,        5'd0}, "rs_x");
    run('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,        5'd0}, "rs_y");
    run('{1'b0, 1'b0, 1'b1, 32'h00000033, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0,        5'd0}, "rs_z");
    run('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h00000033, 5'd12}, "rs_aa");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
